// File: rtl/audio_i2s_pkg.sv
// Shared types and default constants for the WM8731 I2S ADC receiver.
// Status outputs are only built when AUDIO_I2S_RX_STATUS_EN is defined.
package audio_i2s_pkg;

    localparam int AUDIO_DATA_W      = 24;
    localparam int AUDIO_FIFO_DEPTH  = 8;
    localparam int AUDIO_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        WAIT
    } rx_state_t;

    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] left;
        logic [AUDIO_DATA_W-1:0] right;
    } audio_frame_t;

endpackage

// File: rtl/audio_i2s_fifo.sv
// First-word-fall-through frame FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle. Memory is left unreset.
module audio_i2s_fifo
    import audio_i2s_pkg::*;
#(
    parameter int DEPTH = AUDIO_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  audio_frame_t wr_data,
    input  logic         pop,
    output audio_frame_t rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    audio_frame_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           wr_en;
    logic           rd_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_i2s_rx.sv
// I2S ADC receiver: synchronizes codec pins, deserializes stereo frames, queues them.
// Define AUDIO_I2S_RX_STATUS_EN to build the overflow flag and drop counter.
module audio_i2s_rx
    import audio_i2s_pkg::*;
#(
    parameter int DATA_W      = AUDIO_DATA_W,
    parameter int FIFO_DEPTH  = AUDIO_FIFO_DEPTH,
    parameter int SYNC_STAGES = AUDIO_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bclk,
    input  logic              adclrck,
    input  logic              adcdat,
    input  logic              enable,
    output logic [DATA_W-1:0] st_left_data,
    output logic [DATA_W-1:0] st_right_data,
    output logic              st_valid,
    input  logic              st_ready,
    input  logic              clear_status,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
    logic                   bclk_prev, strobe, lrck_s, dat_s, lrck_last;
    logic                   lr_change;

    rx_state_t              state, state_nx;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      shreg, left_hold;
    logic                   chan, left_valid;
    logic                   start, shift_en, abort, done;

    logic                   push, pop, fifo_full, fifo_empty;
    logic                   drop_full, drop_inc;
    audio_frame_t           head;

    // Strobe is registered together with the lrck/data samples it qualifies.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            strobe    <= 1'b0;
            lrck_s    <= 1'b0;
            dat_s     <= 1'b0;
            lrck_last <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], adclrck};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
            strobe    <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
            lrck_s    <= lrck_sync[SYNC_STAGES-1];
            dat_s     <= dat_sync[SYNC_STAGES-1];
            if (strobe)
                lrck_last <= lrck_s;
        end
    end

    assign lr_change = strobe && (lrck_s != lrck_last);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        shift_en = 1'b0;
        abort    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (lr_change && !lrck_s) begin
                    state_nx = SHIFT;
                    start    = 1'b1;
                end
            end
            SHIFT: begin
                if (lr_change) begin
                    abort = 1'b1;
                    start = 1'b1;
                end else if (strobe) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W-1))
                        state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (lr_change) begin
                    state_nx = SHIFT;
                    start    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (!enable) begin
            state_nx = IDLE;
            start    = 1'b0;
            shift_en = 1'b0;
            abort    = 1'b0;
            done     = 1'b0;
        end
    end

    // The change strobe itself is the I2S delay bit, so it only restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            chan       <= 1'b0;
            shreg      <= '0;
            left_hold  <= '0;
            left_valid <= 1'b0;
        end else begin
            if (start) begin
                bit_cnt <= '0;
                chan    <= lrck_s;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {shreg[DATA_W-2:0], dat_s};
            end
            if (!enable || abort)
                left_valid <= 1'b0;
            else if (done && !chan) begin
                left_hold  <= shreg;
                left_valid <= 1'b1;
            end else if (done && chan)
                left_valid <= 1'b0;
        end
    end

    assign push      = done && chan && left_valid;
    assign pop       = st_valid && st_ready;
    assign drop_full = push && fifo_full && !pop;
    assign drop_inc  = abort || drop_full;

    audio_i2s_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data ('{left: left_hold, right: shreg}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign st_valid      = !fifo_empty;
    assign st_left_data  = st_valid ? head.left  : '0;
    assign st_right_data = st_valid ? head.right : '0;

`ifdef AUDIO_I2S_RX_STATUS_EN
    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clear_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop_full)
                overflow <= 1'b1;
            if (drop_inc && drop_count != 16'hFFFF)
                drop_count <= drop_count + 1'b1;
        end
    end
`else
    logic unused_status;
    assign unused_status = ^{clear_status, drop_inc, drop_full};
    assign overflow      = 1'b0;
    assign drop_count    = '0;
`endif

endmodule

// File: doc/audio_i2s_rx.md
# audio_i2s_rx

Fabric-side I2S receiver for the WM8731 ADC path on the DE1-SoC. It takes the codec's BCLK, ADCLRCK and ADCDAT pins (codec is bus master) and samples them with the system clock. It deserializes one stereo frame at a time and buffers the frames in a small FIFO. Frames go out on an Avalon-ST style valid/ready port to the audio core / DSP stage downstream.

## Interface
Parameters:
- DATA_W, 24, sample width per channel; the codec word length must equal DATA_W.
- FIFO_DEPTH, 8, stereo frames buffered; power of two, ≥ 2.
- SYNC_STAGES, 2, synchronizer flops on each codec input; ≥ 2.

Ports:
- clk  in  1  system clock (50 MHz); the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- bclk  in  1  codec bit clock, asynchronous to clk.
- adclrck  in  1  codec ADC word select, asynchronous; low = left, high = right.
- adcdat  in  1  codec ADC serial data, asynchronous.
- enable  in  1  receive enable.
- st_left_data  out  DATA_W  left sample of the head frame.
- st_right_data  out  DATA_W  right sample of the head frame.
- st_valid  out  1  head frame available.
- st_ready  in  1  consumer accepts the head frame.
- clear_status  in  1  single-cycle pulse that clears the status outputs.
- overflow  out  1  sticky flag: a frame was dropped because the FIFO was full.
- drop_count  out  16  saturating count of dropped or aborted frames.

## Operation
- Input conditioning: bclk, adclrck and adcdat each pass through SYNC_STAGES flops. A rising edge of synchronized bclk (current 1, previous 0) produces a one-cycle strobe. All capture happens on strobe cycles only.
- Word-select change: detected on a strobe when the sampled lrck differs from the lrck stored at the previous strobe.
- I2S framing: the strobe on which the lrck change is detected carries the delay bit and is discarded. The next DATA_W strobes carry the word MSB first. Channel is set by the new lrck value.
- FSM states:
  - IDLE: wait for an lrck change to 0, i.e. the start of a left word; go to SHIFT.
  - SHIFT: shift adcdat into the shift register; after DATA_W bits go to DONE.
  - DONE: store or push the word, then go to WAIT.
  - WAIT: ignore slot padding bits until the next lrck change, then go to SHIFT for the new channel.
- Left word in DONE: stored in the left holding register and marks the frame "left valid".
- Right word in DONE:
  - If left valid is set, push {left, right} to the FIFO and clear left valid.
  - If left valid is clear, discard the word.
- Short word: an lrck change while in SHIFT aborts the current word and clears left valid. drop_count increments. The FSM re-enters SHIFT for the new channel.
- FIFO full at push: the frame is dropped, overflow is set and drop_count increments. If a pop happens in the same cycle as the push, the push is accepted.
- Output is first-word-fall-through:
  - st_valid = FIFO not empty.
  - A pop occurs when st_valid && st_ready.
  - Data outputs are forced to 0 whenever st_valid = 0.
- enable = 0: the FSM is forced to IDLE, the partial word and left valid are discarded, and no push occurs. The FIFO keeps its contents and keeps draining.
- drop_count saturates at 16'hFFFF. clear_status zeroes overflow and drop_count; an increment in the same cycle is lost.

## Timing
- Reset values: st_valid 0, st_left_data 0, st_right_data 0, overflow 0, drop_count 0. FSM is IDLE, FIFO is empty, left valid is 0.
- Reset asserted mid-frame discards everything. After reset, reception resumes at the next left word.
- Requirement on bclk: its high and low phases must each last ≥ SYNC_STAGES+1 clk periods. At 50 MHz this covers 64×fs up to 96 kHz.
- Latency: st_valid rises SYNC_STAGES+3 clk cycles after the first clk edge that samples bclk high on the right-word LSB.
  - SYNC_STAGES cycles of synchronization.
  - 1 cycle strobe/shift.
  - 1 cycle DONE/push.
  - 1 cycle FIFO count.
- Throughput: one pop per clk cycle. st_ready has no combinational path to any output other than through the FIFO state.

## Configuration
- AUDIO_I2S_RX_STATUS_EN defined: overflow and drop_count behave as described above.
- AUDIO_I2S_RX_STATUS_EN undefined:
  - overflow and drop_count are tied to 0.
  - clear_status is ignored.
  - The counter and flag logic is not built.
  - Dropping and abort behaviour is unchanged.

## Structure
- Package audio_i2s_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE, WAIT);
  - typedef audio_frame_t, a packed struct {left, right} of DATA_W each;
  - the default constants for DATA_W, FIFO_DEPTH and SYNC_STAGES.
- Sub-module audio_i2s_fifo: synchronous FWFT FIFO of audio_frame_t with push, pop, full and empty. Its memory is not reset; its pointers and count are.
- Synchronizers, edge detection, FSM and status logic live in the top module.

## Test plan
- Reset with bclk idle → st_valid 0, both data outputs 0, overflow 0, drop_count 0.
- clk 50 MHz, bclk 3.072 MHz, one frame left 24'h123456 / right 24'hABCDEF, st_ready=1 → exactly one beat of {24'h123456, 24'hABCDEF}, with st_valid high for one cycle at the specified latency.
- st_ready=0 for 10 frames numbered 1..10, FIFO_DEPTH 8 → frames 1..8 retained, frames 9 and 10 dropped, overflow=1, drop_count=2. Then raising st_ready drains frames 1..8 in order over 8 consecutive cycles.
- Right word cut after 16 bits by an lrck change → no frame pushed, drop_count +1. The following full frame 24'h000001 / 24'hFFFFFF is output correctly.
- Reset released while adclrck is high (mid right word) → no output for that word. The first beat is the next complete left/right pair.
- enable dropped mid left word and re-raised, then clear_status pulsed → partial frame discarded, next complete frame output, overflow and drop_count read 0. With AUDIO_I2S_RX_STATUS_EN undefined, both outputs stay 0 throughout.
